// File: rtl/core_run_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : core_run_pkg                                                  |
// | Description : Shared types and helpers for the core run controller:         |
// |               run-state encoding, the all-ones HALT word source and the     |
// |               program-slot clamp helper.                                    |
// | Ports       : none (package)                                                |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package core_run_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } run_state_e;

   // HALT is the all-ones machine word; users slice the low W bits of this.
   localparam int unsigned HALT_MAX_W = 64;
   localparam logic [HALT_MAX_W-1:0] HALT_ONES = '1;

   // Out-of-range program selects fall back to slot 0.
   function automatic int unsigned slot_index(input int unsigned sel,
                                              input int unsigned nprog);
      return (sel < nprog) ? sel : 32'd0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/run_cycle_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : run_cycle_cnt                                                 |
// | Description : Retired-instruction counter for one run, with synchronous     |
// |               clear, count enable and a terminal-count flag that is high    |
// |               while the count equals TMO-1 (the last allowed instruction).  |
// | Ports       : clk   in  clock                                               |
// |               reset in  synchronous active-low reset                        |
// |               clr   in  clear count to zero (wins over en)                  |
// |               en    in  count one retired instruction                       |
// |               cnt   out registered count                                    |
// |               tc    out count == TMO-1                                      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module run_cycle_cnt #(
   parameter int unsigned CW  = 16,
   parameter int unsigned TMO = 4095
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          tc
);

   localparam logic [CW-1:0] C_TC_VAL = CW'(TMO - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = (cnt_q == C_TC_VAL);

endmodule
`default_nettype wire

// File: rtl/core_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : core_run_ctrl                                                 |
// | Description : Run controller for the single-cycle core. Accepts a four-     |
// |               phase req/done handshake, loads the PC with the start address |
// |               of the selected program slot and qualifies execution until    |
// |               a HALT word or an instruction-count timeout.                  |
// |               Integration: the PC advances only when run_en is high,        |
// |               RegWrite/MemWrite are ANDed with run_en, and pc_load takes    |
// |               priority over any branch target.                              |
// | Ports       : clk         in  clock                                         |
// |               reset       in  synchronous active-low reset                  |
// |               req         in  run request (level)                           |
// |               prog_sel    in  program slot, sampled on accept               |
// |               mach_code   in  current instruction word                      |
// |               prog_ctr    in  current PC                                    |
// |               pc_load     out load PC with pc_load_val                      |
// |               pc_load_val out start address (0 outside LOAD)                |
// |               run_en      out execution qualifier (combinational)           |
// |               busy        out high in LOAD and RUN                          |
// |               done        out run finished, held until req drops            |
// |               timeout     out last run ended by timeout                     |
// |               cycle_cnt   out instructions retired in last/current run      |
// |               halt_pc     out PC of the HALT of the last run                |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module core_run_ctrl
   import core_run_pkg::*;
#(
   parameter int unsigned             D         = 12,
   parameter int unsigned             W         = 9,
   parameter int unsigned             NPROG     = 3,
   parameter logic [NPROG*D-1:0]      START_VEC = {12'd512, 12'd256, 12'd0},
   parameter int unsigned             CW        = 16,
   parameter int unsigned             TMO       = 4095,
   localparam int unsigned            SW        = (NPROG > 1) ? $clog2(NPROG) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic [SW-1:0] prog_sel,
   input  logic [W-1:0]  mach_code,
   input  logic [D-1:0]  prog_ctr,
   output logic          pc_load,
   output logic [D-1:0]  pc_load_val,
   output logic          run_en,
   output logic          busy,
   output logic          done,
   output logic          timeout,
   output logic [CW-1:0] cycle_cnt,
   output logic [D-1:0]  halt_pc
);

   localparam logic [W-1:0] C_HALT = HALT_ONES[W-1:0];

   run_state_e    state_q, state_d;
   logic          pc_load_q, pc_load_d;
   logic [D-1:0]  pc_load_val_q, pc_load_val_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          timeout_q, timeout_d;
   logic [D-1:0]  halt_pc_q, halt_pc_d;

   logic          is_halt;
   logic          run_en_w;
   logic          cnt_clr;
   logic          cnt_tc;
   logic [SW-1:0] slot;
   logic [D-1:0]  start_tbl [NPROG];

   for (genvar gi = 0; gi < NPROG; gi++) begin : g_slot
      assign start_tbl[gi] = START_VEC[gi*D +: D];
   end

   assign slot     = SW'(slot_index(32'(prog_sel), NPROG));
   assign is_halt  = (mach_code == C_HALT);
   // A HALT word never retires: it suppresses PC advance and writes.
   assign run_en_w = (state_q == ST_RUN) && !is_halt;
   // Clearing on accept makes the per-run status read zero already in LOAD.
   assign cnt_clr  = (state_q == ST_IDLE) && req;

   run_cycle_cnt #(
      .CW  (CW),
      .TMO (TMO)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (run_en_w),
      .cnt   (cycle_cnt),
      .tc    (cnt_tc)
   );

   always_comb begin
      state_d       = state_q;
      pc_load_d     = 1'b0;
      pc_load_val_d = '0;
      timeout_d     = timeout_q;
      halt_pc_d     = halt_pc_q;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d       = ST_LOAD;
               pc_load_d     = 1'b1;
               pc_load_val_d = start_tbl[slot];
               timeout_d     = 1'b0;
               halt_pc_d     = '0;
            end
         end
         ST_LOAD: begin
            state_d = req ? ST_RUN : ST_IDLE;
         end
         ST_RUN: begin
            // Abort outranks completion; HALT outranks timeout.
            if (!req) begin
               state_d = ST_IDLE;
            end else if (is_halt) begin
               halt_pc_d = prog_ctr;
               state_d   = ST_DONE;
            end else if (cnt_tc) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!req) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         pc_load_q     <= 1'b0;
         pc_load_val_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         timeout_q     <= 1'b0;
         halt_pc_q     <= '0;
      end else begin
         state_q       <= state_d;
         pc_load_q     <= pc_load_d;
         pc_load_val_q <= pc_load_val_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         timeout_q     <= timeout_d;
         halt_pc_q     <= halt_pc_d;
      end
   end

   assign pc_load     = pc_load_q;
   assign pc_load_val = pc_load_val_q;
   assign run_en      = run_en_w;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout     = timeout_q;
   assign halt_pc     = halt_pc_q;

endmodule
`default_nettype wire

// File: doc/core_run_ctrl.md
# core_run_ctrl

Parametrised run controller that sequences program execution for the single-cycle core. Accepts a four-phase `req`/`done` handshake, selects one of `NPROG` program start addresses, loads the PC, and gates execution until a HALT instruction or a cycle timeout. Sits between the top-level handshake pins and the PC / write-enable paths, replacing the fixed single-program start with multi-program, abortable, bounded runs.

## Interface
- `D`, 12: PC width
- `W`, 9: machine code width
- `NPROG`, 3: number of program slots
- `START_VEC`, {12'd512,12'd256,12'd0}: packed start addresses; slot i at bits [i*D +: D]
- `CW`, 16: cycle counter width
- `TMO`, 4095: max retired instructions per run (1 ≤ TMO ≤ 2^CW−1)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `req`  in  1  run request (level, four-phase)
- `prog_sel`  in  $clog2(NPROG)  program slot, sampled on accept
- `mach_code`  in  W  current instruction from instruction ROM
- `prog_ctr`  in  D  current PC value
- `pc_load`  out  1  load PC with `pc_load_val` at next edge
- `pc_load_val`  out  D  start address of selected slot
- `run_en`  out  1  PC advance / RegWrite / MemWrite qualifier
- `busy`  out  1  high in LOAD and RUN
- `done`  out  1  run finished, held until `req` low
- `timeout`  out  1  last run ended by timeout
- `cycle_cnt`  out  CW  instructions retired in last/current run
- `halt_pc`  out  D  PC of HALT instruction of last run

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: `req`=1 → latch `prog_sel` (values ≥ NPROG clamp to slot 0) → LOAD.
- LOAD (1 cycle): `pc_load`=1, `pc_load_val`=START_VEC slot; clear `cycle_cnt`, `timeout`, `halt_pc`; `run_en`=0 → RUN.
- RUN: `run_en` = (`mach_code` ≠ HALT), combinational. HALT = all-ones W-bit word.
  - HALT seen: latch `halt_pc`=`prog_ctr`, `cycle_cnt` not incremented → DONE.
  - else: `cycle_cnt`++; if pre-increment `cycle_cnt` = TMO−1 → `timeout`=1 → DONE.
  - HALT and timeout in same cycle: HALT wins, `timeout`=0.
- DONE: `done`=1, `run_en`=0; `req`=0 → IDLE.
- Abort: `req`=0 in LOAD or RUN → IDLE next edge; `done` never asserts; `cycle_cnt` keeps partial count; `timeout` stays 0.
- `cycle_cnt`, `halt_pc`, `timeout` hold through DONE and IDLE until next LOAD.
- `pc_load_val` driven 0 outside LOAD.

## Timing
- Reset (`reset`=0 at edge): state IDLE; all outputs 0 next cycle, including mid-run.
- `req` high at edge N in IDLE → LOAD during cycle N+1 → first instruction at start address executes in cycle N+2 with `run_en`=1.
- `done` rises one cycle after the HALT/timeout cycle; falls one cycle after `req` sampled low.
- `req` held high after `done` falls is impossible (DONE exits only on `req`=0); a new run needs `req` low for ≥1 edge, then high.
- `run_en` is the only combinational output; all others are registered.

## Structure
- Package `core_run_pkg`: state enum (IDLE, LOAD, RUN, DONE), HALT constant derived from W, slot-index helper.
- One sub-module: `run_cycle_cnt` (clear, enable, terminal-count compare against TMO−1).
- Top-level integration: PC increments only when `run_en`; RegWrite/MemWrite ANDed with `run_en`; `pc_load` overrides branch.

## Test plan
- Reset: hold `reset`=0 three cycles with `req`=1 → all outputs 0, state IDLE; release → LOAD one cycle later.
- Normal run: `prog_sel`=1, ROM returns HALT at PC 259 → `pc_load`=1 with 256 for one cycle, `run_en` high 3 cycles, `done`=1, `cycle_cnt`=3, `halt_pc`=259, `timeout`=0.
- Timeout: TMO=8, no HALT in program → `run_en` high exactly 8 cycles, `done`=1, `timeout`=1, `cycle_cnt`=8.
- Tie: TMO=8, HALT at 9th RUN cycle vs HALT at 8th → HALT at 8th gives `timeout`=0, `cycle_cnt`=7; HALT at 9th never reached (timeout=1, `cycle_cnt`=8).
- Abort: drop `req` in 2nd RUN cycle → IDLE next edge, `busy`=0, `done` never high, `cycle_cnt`=2.
- Out-of-range / mid-run reset: `prog_sel`=3 → `pc_load_val`=0; assert `reset` in RUN → all outputs 0 next cycle, new `req` runs normally.
